// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard unit.
// Contains the forwarding-select encodings used by the datapath muxes
// and a small helper for sizing parameter-dependent counters.
package hazard_ctrl_pkg;

  // Forwarding mux select encodings. The datapath muxes decode these.
  // FWD_E is only meaningful for the D-stage selects.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // Larger of two integers; used to size the HI/LO busy counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// HI/LO unit busy tracker: loads the mult/div latency when a mult/div
// occupies E and counts down to zero otherwise.
// Ports: clk/reset; e_md_start/e_md_div from the E record; md_busy output.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic e_md_start,
  input  logic e_md_div,
  output logic md_busy
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (e_md_start) begin
      cnt_next = e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // The unit is already busy while the mult/div sits in E, one cycle
  // before the counter is loaded.
  assign md_busy = (cnt != '0) | e_md_start;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: shadow records of the producers
// in E/M/W drive the stall, the D/E forwarding selects and the HI/LO interlock.
// Ports: D-stage operand/producer info in; stall, fwd_d_rs/rt, fwd_e_rs/rt,
// md_busy out. All outputs are combinational from the records and D inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic [REG_AW-1:0] d_a3,
  input  logic              d_we,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              md_busy
);

  // A tuse of all-ones marks an operand the instruction does not read.
  localparam logic [T_W-1:0] TUSE_NONE = '1;

  // E record
  logic [REG_AW-1:0] e_rs, e_rt, e_a3;
  logic              e_we;
  logic [T_W-1:0]    e_tnew;
  logic              e_md_start, e_md_div;

  // M and W records
  logic [REG_AW-1:0] m_a3, w_a3;
  logic              m_we, w_we;
  logic [T_W-1:0]    m_tnew, w_tnew;

  logic reg_stall;
  logic md_stall;

  fwd_sel_e fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel;

  // Saturating decrement: a result already available stays available.
  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // A record produces operand x when it writes a non-zero register equal to x.
  function automatic logic hit(input logic              we,
                               input logic [REG_AW-1:0] a3,
                               input logic [REG_AW-1:0] x);
    return we && (a3 == x) && (x != '0);
  endfunction

  // Operand x is needed in tuse cycles; stall if the E or M producer
  // will not have its value ready by then.
  function automatic logic need_stall(input logic [REG_AW-1:0] x,
                                      input logic [T_W-1:0]    tuse);
    logic s;
    s = 1'b0;
    if (tuse != TUSE_NONE) begin
      if (hit(e_we, e_a3, x) && (tuse < e_tnew)) s = 1'b1;
      if (hit(m_we, m_a3, x) && (tuse < m_tnew)) s = 1'b1;
    end
    return s;
  endfunction

  // D-stage source: nearest matching producer wins; if it has not
  // produced its value yet it still shadows older producers, so the
  // select stays on the register file.
  function automatic fwd_sel_e d_sel(input logic [REG_AW-1:0] x);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (hit(e_we, e_a3, x)) begin
      sel = (e_tnew == '0) ? FWD_E : FWD_RF;
    end else if (hit(m_we, m_a3, x)) begin
      sel = (m_tnew == '0) ? FWD_M : FWD_RF;
    end else if (hit(w_we, w_a3, x)) begin
      sel = (w_tnew == '0) ? FWD_W : FWD_RF;
    end
    return sel;
  endfunction

  // E-stage source: same nearest-first rule over M and W.
  function automatic fwd_sel_e e_sel(input logic [REG_AW-1:0] x);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (hit(m_we, m_a3, x)) begin
      sel = (m_tnew == '0) ? FWD_M : FWD_RF;
    end else if (hit(w_we, w_a3, x)) begin
      sel = (w_tnew == '0) ? FWD_W : FWD_RF;
    end
    return sel;
  endfunction

  always_comb begin
    reg_stall    = need_stall(d_rs, d_tuse_rs) | need_stall(d_rt, d_tuse_rt);
    fwd_d_rs_sel = d_sel(d_rs);
    fwd_d_rt_sel = d_sel(d_rt);
    fwd_e_rs_sel = e_sel(e_rs);
    fwd_e_rt_sel = e_sel(e_rt);
  end

  assign md_stall = d_md_use & md_busy;
  assign stall    = reg_stall | md_stall;

  assign fwd_d_rs = fwd_d_rs_sel;
  assign fwd_d_rt = fwd_d_rt_sel;
  assign fwd_e_rs = fwd_e_rs_sel;
  assign fwd_e_rt = fwd_e_rt_sel;

  // Record pipeline. A stalled D instruction leaves a bubble in E, so a
  // stalled mult/div never starts the counter twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rs       <= '0;
      e_rt       <= '0;
      e_a3       <= '0;
      e_we       <= 1'b0;
      e_tnew     <= '0;
      e_md_start <= 1'b0;
      e_md_div   <= 1'b0;
      m_a3       <= '0;
      m_we       <= 1'b0;
      m_tnew     <= '0;
      w_a3       <= '0;
      w_we       <= 1'b0;
      w_tnew     <= '0;
    end else begin
      if (stall) begin
        e_rs       <= '0;
        e_rt       <= '0;
        e_a3       <= '0;
        e_we       <= 1'b0;
        e_tnew     <= '0;
        e_md_start <= 1'b0;
        e_md_div   <= 1'b0;
      end else begin
        e_rs       <= d_rs;
        e_rt       <= d_rt;
        e_a3       <= d_a3;
        e_we       <= d_we;
        e_tnew     <= d_tnew;
        e_md_start <= d_md_start;
        e_md_div   <= d_md_div;
      end
      m_a3   <= e_a3;
      m_we   <= e_we;
      m_tnew <= sat_dec(e_tnew);
      w_a3   <= m_a3;
      w_we   <= m_we;
      w_tnew <= sat_dec(m_tnew);
    end
  end

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk       (clk),
    .reset     (reset),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .md_busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, jal/jr, $0,
// mult/div interlock and asynchronous reset.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_we, d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_AW(5), .T_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_a3      (d_a3),
    .d_we      (d_we),
    .d_tnew    (d_tnew),
    .d_md_start(d_md_start),
    .d_md_div  (d_md_div),
    .d_md_use  (d_md_use),
    .stall     (stall),
    .fwd_d_rs  (fwd_d_rs),
    .fwd_d_rt  (fwd_d_rt),
    .fwd_e_rs  (fwd_e_rs),
    .fwd_e_rt  (fwd_e_rt),
    .md_busy   (md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tuse_rs,
                       input logic [4:0] rt, input logic [1:0] tuse_rt,
                       input logic [4:0] a3, input logic we, input logic [1:0] tnew,
                       input logic mds, input logic mdd, input logic mdu);
    d_rs = rs; d_tuse_rs = tuse_rs; d_rt = rt; d_tuse_rt = tuse_rt;
    d_a3 = a3; d_we = we; d_tnew = tnew;
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    nop();
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Hold an mflo-like reader in D, count stalled cycles (bounded).
  task automatic md_wait(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (stall && n < 40) begin
      n++;
      tick();
    end
    check(tag, n, exp_cycles);
    check({tag, "_busy_after"}, md_busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    #2;
    check("rst_stall", stall, 0);
    check("rst_busy", md_busy, 0);
    check("rst_fwd_d_rs", fwd_d_rs, 0);
    check("rst_fwd_e_rs", fwd_e_rs, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();

    // lw $1 (tnew=2) then addu $4,$1,$0 (tuse=1)
    set_d(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd1, 2'd1, 5'd0, 2'd1, 5'd4, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("lw_stall_e", stall, 1);
    check("lw_fwd_d_blocked_e", fwd_d_rs, 0);
    tick();
    // lw in M with tnew=1: tuse=1 is not < 1, no stall; M still blocks.
    check("lw_stall_m", stall, 0);
    check("lw_fwd_d_blocked_m", fwd_d_rs, 0);
    tick();
    nop();
    check("lw_fwd_e_rs_w", fwd_e_rs, 3);
    check("lw_fwd_e_rt_zero", fwd_e_rt, 0);
    flush();

    // ori $3 (tnew=1) then beq $3 (tuse_rs=0)
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("beq_stall", stall, 1);
    tick();
    check("beq_stall_clear", stall, 0);
    check("beq_fwd_d_rs_m", fwd_d_rs, 2);
    check("beq_fwd_d_rt_rf", fwd_d_rt, 0);
    tick();
    nop();
    check("beq_fwd_e_rs_w", fwd_e_rs, 3);
    flush();

    // jal (a3=31, tnew=0) then jr $31
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("jr_stall", stall, 0);
    check("jr_fwd_d_rs_e", fwd_d_rs, 1);
    set_d(5'd0, 2'd3, 5'd31, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("jr_fwd_d_rt_e", fwd_d_rt, 1);
    flush();

    // addu $0 (tnew=1) then a reader of $0
    set_d(5'd0, 2'd1, 5'd0, 2'd1, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("zero_stall", stall, 0);
    check("zero_fwd_d_rs", fwd_d_rs, 0);
    flush();

    // div then mflo: 1 (div in E) + 10 busy cycles
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    check("div_enter_no_stall", stall, 0);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    check("div_busy_in_e", md_busy, 1);
    md_wait("div_stall_cycles", 11);
    flush();

    // mult then mflo: 1 + 5
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    md_wait("mult_stall_cycles", 6);
    flush();

    // Reset while cnt=4 and a producer ($7) sits in M
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();                                    // mult in E
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();                                    // cnt=5, addu in E
    nop();
    tick();                                    // cnt=4, addu in M (tnew=0)
    set_d(5'd7, 2'd0, 5'd7, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("pre_rst_busy", md_busy, 1);
    check("pre_rst_stall", stall, 1);
    check("pre_rst_fwd_d_rs_m", fwd_d_rs, 2);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", md_busy, 0);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_fwd_d_rs", fwd_d_rs, 0);
    check("rst_mid_fwd_d_rt", fwd_d_rt, 0);
    check("rst_mid_fwd_e_rs", fwd_e_rs, 0);
    check("rst_mid_fwd_e_rt", fwd_e_rt, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("post_rst_busy", md_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
